// File: rtl/de_cipher.sv
// AES-128 inverse cipher, one round per clock, key schedule run forward to rk10 then unwound.
// Latency: done pulses 21 edges after the accepting edge; start is ignored while busy.
module de_cipher (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, KEYEXP, INIT, ROUND} state_t;

  state_t       state_q, state_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, out_q, out_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d, done_q, done_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, x;
    r = 8'h01;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gmul(r, x);
      x = gmul(x, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // byte r+4c sits at bits [127-8*(r+4c) -: 8]
  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gmul(s[127-8*(r+4*c) -: 8], 8'h0e)
                              ^ gmul(s[127-8*((r+1)%4+4*c) -: 8], 8'h0b)
                              ^ gmul(s[127-8*((r+2)%4+4*c) -: 8], 8'h0d)
                              ^ gmul(s[127-8*((r+3)%4+4*c) -: 8], 8'h09);
    return o;
  endfunction

  // One SubWord serves both directions: w3 going forward, w3^w2 going back
  logic [31:0]  sw_in, t_word;
  logic [31:0]  w0, w1, w2, w3;
  logic [127:0] rk_fwd, rk_inv, s_round;

  assign w0 = rk_q[127:96];
  assign w1 = rk_q[95:64];
  assign w2 = rk_q[63:32];
  assign w3 = rk_q[31:0];
  assign sw_in  = (state_q == KEYEXP) ? w3 : (w3 ^ w2);
  assign t_word = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])}
                ^ {rcon(cnt_q), 24'h000000};
  assign rk_fwd = {w0 ^ t_word, w1 ^ w0 ^ t_word, w2 ^ w1 ^ w0 ^ t_word, w3 ^ w2 ^ w1 ^ w0 ^ t_word};
  assign rk_inv = {w0 ^ t_word, w1 ^ w0, w2 ^ w1, w3 ^ w2};
  assign s_round = inv_shift_sub(st_q) ^ rk_inv;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        st_d    = in;
        rk_d    = key;
        cnt_d   = 4'd1;
        busy_d  = 1'b1;
        state_d = KEYEXP;
      end
      KEYEXP: begin
        rk_d = rk_fwd;
        if (cnt_q == 4'd10) state_d = INIT;
        else                cnt_d = cnt_q + 4'd1;
      end
      INIT: begin
        st_d    = st_q ^ rk_q;
        cnt_d   = 4'd10;
        state_d = ROUND;
      end
      ROUND: begin
        rk_d = rk_inv;
        if (cnt_q == 4'd1) begin
          st_d    = s_round;
          out_d   = s_round;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          st_d  = inv_mix(s_round);
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_de_cipher.sv
// Directed bench for de_cipher: FIPS-197 vectors, latency, ignored start, async reset, back-to-back.
module tb_de_cipher;

  localparam logic [127:0] V1_IN  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] V1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1_OUT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] V1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] V2_IN  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] V2_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] V2_OUT = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] V3_IN  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] din = '0;
  logic [127:0] key = '0;
  logic [127:0] dout;
  logic         busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  de_cipher dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .in   (din),
    .key  (key),
    .out  (dout),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [127:0] c, input logic [127:0] k, input logic [127:0] p,
                       input string tag, input bit inj, input bit chk_rk);
    int n;
    int busy_drop;
    @(negedge clk);
    start = 1'b1; din = c; key = k;
    @(posedge clk); #1;
    start = 1'b0; din = ~c; key = ~k;
    n = 0;
    busy_drop = 0;
    while (!done && n < 40) begin
      if (!busy) busy_drop++;
      if (inj) begin
        start = (n == 5);
        if (n == 5) begin din = V2_IN; key = V2_KEY; end
      end
      @(posedge clk); #1;
      n++;
      if (chk_rk && n == 10) check({tag, "_rk10"}, dut.rk_q, V1_RK10);
    end
    start = 1'b0;
    check({tag, "_latency"}, n, 21);
    check({tag, "_out"}, dout, p);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_busy_held"}, busy_drop, 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_out_hold"}, dout, p);
  endtask

  initial begin
    int e, first, second, hold_bad;
    #12;
    check("rst_out", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(V1_IN, V1_KEY, V1_OUT, "fips_c1", 1'b0, 1'b1);
    do_op(V2_IN, V2_KEY, V2_OUT, "fips_b", 1'b0, 1'b0);
    do_op(V3_IN, '0, '0, "zero_key", 1'b0, 1'b0);
    do_op(V1_IN, V1_KEY, V1_OUT, "start_busy", 1'b1, 1'b0);

    // abort mid-operation; out still holds the previous nonzero result
    @(negedge clk);
    start = 1'b1; din = V2_IN; key = V2_KEY;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out", dout, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(V2_IN, V2_KEY, V2_OUT, "after_rst", 1'b0, 1'b0);

    // start held high: second block is accepted on the edge right after done
    @(negedge clk);
    start = 1'b1; din = V1_IN; key = V1_KEY;
    @(posedge clk); #1;
    din = V2_IN; key = V2_KEY;
    e = 0; first = -1; second = -1; hold_bad = 0;
    while (e < 60 && second < 0) begin
      @(posedge clk); #1;
      e++;
      if (done) begin
        if (first < 0) begin
          first = e;
          check("b2b_out1", dout, V1_OUT);
        end else begin
          second = e;
        end
      end else if (first >= 0 && dout !== V1_OUT) begin
        hold_bad++;
      end
      if (first >= 0 && e == first + 1) start = 1'b0;
    end
    start = 1'b0;
    check("b2b_first", first, 21);
    check("b2b_gap", second - first, 22);
    check("b2b_out2", dout, V2_OUT);
    check("b2b_hold", hold_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
